// File: rtl/i2c_slave_regs.sv
// I2C slave with a byte-wide register bank. SCL/SDA are oversampled on clk.
// Bus writes: START, addr+W, pointer, data..., STOP. Bus reads start at the
// current pointer, which auto-increments and persists across transactions.
// A host-side combinational read port and a write strobe expose the bank.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         REG_AW     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  input  logic [REG_AW-1:0] reg_raddr,
  output logic [7:0]        reg_rdata,
  output logic              wr_stb,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy
);

  localparam int NREG = 1 << REG_AW;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK, S_IGNORE
  } state_t;

  state_t state, state_n;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  logic [7:0]        regs [NREG];
  logic [7:0]        sr, sr_n;
  logic [3:0]        cnt, cnt_n;
  logic [REG_AW-1:0] ptr, ptr_n, ptr_inc;
  logic              rw, rw_n;
  logic              oe_n, busy_n, stb_n, we;
  logic [REG_AW-1:0] waddr_n;
  logic [7:0]        wdata_n, byte_in;
  logic              scl_rise, scl_fall, start_det, stop_det;

  // Two-flop synchronisers plus one delay stage per line for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      {scl_s1, scl_s2, scl_d} <= 3'b000;
      {sda_s1, sda_s2, sda_d} <= 3'b000;
    end else begin
      {scl_s1, scl_s2, scl_d} <= {scl_i, scl_s1, scl_s2};
      {sda_s1, sda_s2, sda_d} <= {sda_i, sda_s1, sda_s2};
    end
  end

  assign scl_rise  = scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 & scl_d;
  assign start_det = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_det  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign byte_in   = {sr[6:0], sda_s2};
  assign ptr_inc   = ptr + 1'b1;
  assign reg_rdata = regs[reg_raddr];

  // Next-state and datapath decisions; bus conditions override every state.
  // ACK phases use sda_oe itself as the phase bit: first fall asserts, second releases.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sr_n    = sr;
    ptr_n   = ptr;
    rw_n    = rw;
    oe_n    = sda_oe;
    busy_n  = busy;
    stb_n   = 1'b0;
    we      = 1'b0;
    waddr_n = wr_addr;
    wdata_n = wr_data;
    if (start_det) begin
      state_n = S_ADDR;
      cnt_n   = 4'd0;
      oe_n    = 1'b0;
      busy_n  = 1'b1;
    end else if (stop_det) begin
      state_n = S_IDLE;
      oe_n    = 1'b0;
      busy_n  = 1'b0;
    end else begin
      case (state)
        S_ADDR, S_PTR, S_WDATA: begin
          if (scl_rise) begin
            sr_n  = byte_in;
            cnt_n = cnt + 4'd1;
            if (cnt == 4'd7) begin
              cnt_n = 4'd0;
              if (state == S_ADDR) begin
                if (byte_in[7:1] == SLAVE_ADDR) begin
                  rw_n    = byte_in[0];
                  state_n = S_ADDR_ACK;
                end else begin
                  state_n = S_IGNORE;
                end
              end else if (state == S_PTR) begin
                ptr_n   = byte_in[REG_AW-1:0];
                state_n = S_PTR_ACK;
              end else begin
                we      = 1'b1;
                stb_n   = 1'b1;
                waddr_n = ptr;
                wdata_n = byte_in;
                ptr_n   = ptr_inc;
                state_n = S_WDATA_ACK;
              end
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            if (!sda_oe) begin
              oe_n = 1'b1;
            end else begin
              oe_n  = 1'b0;
              cnt_n = 4'd0;
              if (state == S_ADDR_ACK && rw) begin
                // The fall that ends the ACK also presents the first read bit.
                oe_n    = ~regs[ptr][7];
                sr_n    = {regs[ptr][6:0], 1'b0};
                cnt_n   = 4'd1;
                state_n = S_RDATA;
              end else if (state == S_ADDR_ACK) begin
                state_n = S_PTR;
              end else begin
                state_n = S_WDATA;
              end
            end
          end
        end
        S_RDATA: begin
          if (scl_fall) begin
            if (cnt == 4'd8) begin
              oe_n    = 1'b0;
              state_n = S_RACK;
            end else begin
              oe_n  = ~sr[7];
              sr_n  = {sr[6:0], 1'b0};
              cnt_n = cnt + 4'd1;
            end
          end
        end
        S_RACK: begin
          if (scl_rise) begin
            ptr_n = ptr_inc;
            if (!sda_s2) begin
              sr_n    = regs[ptr_inc];
              cnt_n   = 4'd0;
              state_n = S_RDATA;
            end else begin
              state_n = S_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, control and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      sr      <= 8'd0;
      ptr     <= '0;
      rw      <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      wr_stb  <= 1'b0;
      wr_addr <= '0;
      wr_data <= 8'd0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      sr      <= sr_n;
      ptr     <= ptr_n;
      rw      <= rw_n;
      sda_oe  <= oe_n;
      busy    <= busy_n;
      wr_stb  <= stb_n;
      wr_addr <= waddr_n;
      wr_data <= wdata_n;
    end
  end

  // Register bank; a bus write lands at the end of the cycle, so a same-cycle
  // host read still sees the old byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'd0;
    end else if (we) begin
      regs[ptr] <= byte_in;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: a bit-level I2C master drives the pins, a
// scoreboard queue holds expected bus responses and write strobes, and a
// monitor process pops and compares as the DUT produces them.
module tb_i2c_slave_regs;

  localparam int T = 8;  // clk cycles per SCL low / high phase

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl, m_sda_low;
  logic       scl_i, sda_i, sda_oe;
  logic [3:0] reg_raddr;
  logic [7:0] reg_rdata;
  logic       wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int n_cmp = 0;
  int n_fail = 0;
  logic oe_seen = 1'b0;

  // {tag, value}: tag 01 = sda level at 9th clock, tag 02 = read byte
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];
  logic [11:0] exp_wr_q[$];  // {addr, data}

  // Clock and open-drain bus model
  always #5 clk = ~clk;
  assign scl_i = m_scl;
  assign sda_i = ~(sda_oe | m_sda_low);

  i2c_slave_regs dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .reg_raddr(reg_raddr), .reg_rdata(reg_rdata), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [15:0] e, o;
    logic [11:0] w;
    if (sda_oe) oe_seen = 1'b1;
    if (wr_stb) begin
      if (exp_wr_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL wr_stb_unexpected: got addr %0h data %0h expected no strobe", wr_addr, wr_data);
      end else begin
        w = exp_wr_q.pop_front();
        check("wr_stb_addr_data", {wr_addr, wr_data}, w);
      end
    end
    if (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      if (exp_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL bus_rsp_unexpected: got %0h expected nothing", o);
      end else begin
        e = exp_q.pop_front();
        check(e[15:8] == 8'h01 ? "bus_ack" : "bus_rdata", o, e);
      end
    end
  end

  // Watchdog
  initial begin
    #500000;
    n_cmp++; n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic drive_low, output logic sampled);
    m_sda_low = drive_low;
    wait_clks(T);
    m_scl = 1'b1;
    wait_clks(T / 2);
    sampled = sda_i;
    wait_clks(T / 2);
    m_scl = 1'b0;
    wait_clks(2);
  endtask

  task automatic bus_start();
    m_sda_low = 1'b0; m_scl = 1'b1; wait_clks(T);
    m_sda_low = 1'b1; wait_clks(T);
    m_scl = 1'b0; wait_clks(2);
  endtask

  task automatic bus_rstart();
    m_sda_low = 1'b0; wait_clks(T);
    m_scl = 1'b1; wait_clks(T);
    m_sda_low = 1'b1; wait_clks(T);
    m_scl = 1'b0; wait_clks(2);
  endtask

  task automatic bus_stop();
    m_sda_low = 1'b1; wait_clks(T);
    m_scl = 1'b1; wait_clks(T);
    m_sda_low = 1'b0; wait_clks(T);
  endtask

  // exp_sda: SDA level expected at the 9th clock (0 = ACK)
  task automatic write_byte(input logic [7:0] b, input logic exp_sda);
    logic s;
    exp_q.push_back({8'h01, 7'd0, exp_sda});
    for (int i = 7; i >= 0; i--) clock_bit(~b[i], s);
    clock_bit(1'b0, s);
    obs_q.push_back({8'h01, 7'd0, s});
  endtask

  task automatic read_byte(input logic [7:0] exp, input logic master_ack);
    logic s;
    logic [7:0] d;
    d = 8'd0;
    exp_q.push_back({8'h02, exp});
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b0, s);
      d = {d[6:0], s};
    end
    clock_bit(master_ack, s);
    m_sda_low = 1'b0;
    obs_q.push_back({8'h02, d});
  endtask

  task automatic check_reg(input logic [3:0] a, input logic [7:0] exp);
    reg_raddr = a;
    #1;
    check($sformatf("reg_rdata@%0d", a), reg_rdata, exp);
  endtask

  initial begin
    rst = 1'b1; m_scl = 1'b1; m_sda_low = 1'b0; reg_raddr = 4'd0;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(5);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_wr_stb", wr_stb, 0);
    check("reset_wr_addr", wr_addr, 0);
    check("reset_wr_data", wr_data, 0);
    check("reset_busy", busy, 0);
    check_reg(4'd0, 8'h00);

    // Write burst
    bus_start();
    check("busy_after_start", busy, 1);
    write_byte(8'hA0, 1'b0);
    write_byte(8'h03, 1'b0);
    exp_wr_q.push_back({4'd3, 8'h11});
    write_byte(8'h11, 1'b0);
    exp_wr_q.push_back({4'd4, 8'h22});
    write_byte(8'h22, 1'b0);
    bus_stop();
    check("busy_after_stop", busy, 0);
    check("wr_addr_held", wr_addr, 4);
    check("wr_data_held", wr_data, 8'h22);
    check_reg(4'd3, 8'h11);
    check_reg(4'd4, 8'h22);

    // Combined read, then a pointer-less read continuing at reg[5]
    bus_start();
    write_byte(8'hA0, 1'b0);
    write_byte(8'h03, 1'b0);
    bus_rstart();
    write_byte(8'hA1, 1'b0);
    read_byte(8'h11, 1'b1);
    read_byte(8'h22, 1'b0);
    bus_stop();
    bus_start();
    write_byte(8'hA1, 1'b0);
    read_byte(8'h00, 1'b0);
    bus_stop();

    // Address mismatch
    wait_clks(4);
    oe_seen = 1'b0;
    bus_start();
    write_byte(8'hA2, 1'b1);
    write_byte(8'h05, 1'b1);
    bus_stop();
    check("mismatch_oe_never", oe_seen, 0);
    check_reg(4'd5, 8'h00);

    // Pointer wrap
    bus_start();
    write_byte(8'hA0, 1'b0);
    write_byte(8'h0F, 1'b0);
    exp_wr_q.push_back({4'd15, 8'hAA});
    write_byte(8'hAA, 1'b0);
    exp_wr_q.push_back({4'd0, 8'hBB});
    write_byte(8'hBB, 1'b0);
    bus_stop();
    check_reg(4'd15, 8'hAA);
    check_reg(4'd0, 8'hBB);

    // Upper pointer bits ignored
    bus_start();
    write_byte(8'hA0, 1'b0);
    write_byte(8'h13, 1'b0);
    exp_wr_q.push_back({4'd3, 8'h5C});
    write_byte(8'h5C, 1'b0);
    bus_stop();
    check_reg(4'd3, 8'h5C);

    // Reset while the slave drives bit 7 (=0) of reg[3]
    bus_start();
    write_byte(8'hA0, 1'b0);
    write_byte(8'h03, 1'b0);
    bus_rstart();
    write_byte(8'hA1, 1'b0);
    wait_clks(T);
    check("read_bit7_driven_low", sda_oe, 1);
    rst = 1'b1;
    wait_clks(1);
    rst = 1'b0;
    check("midrst_sda_oe", sda_oe, 0);
    check("midrst_busy", busy, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_wr_data", wr_data, 0);
    for (int i = 0; i < 16; i++) check_reg(4'(i), 8'h00);
    bus_stop();

    // Normal write after reset
    bus_start();
    write_byte(8'hA0, 1'b0);
    write_byte(8'h07, 1'b0);
    exp_wr_q.push_back({4'd7, 8'h3C});
    write_byte(8'h3C, 1'b0);
    bus_stop();
    check_reg(4'd7, 8'h3C);

    wait_clks(20);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_wr_q_drained", exp_wr_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

Synthesizable I2C slave with a small byte-wide register bank. It sits on the far end of the I2C bus driven by `i2c_master_controller_top` and consumes the SCL/SDA traffic that the master controller produces. In the top-level bench it replaces the behavioural slave, so master write/read sequences can be checked against real register contents. A host-side read port and write-strobe outputs let the bench or surrounding logic observe every bus write.

## Interface
- `SLAVE_ADDR`, 7'h50: 7-bit bus address the block responds to.
- `REG_AW`, 4: register pointer width; the bank holds 2^REG_AW bytes.

- `clk`  in  1  system clock; SCL/SDA are oversampled on it.
- `rst`  in  1  reset, synchronous, active-high.
- `scl_i`  in  1  SCL pin level. Asynchronous to `clk`.
- `sda_i`  in  1  SDA pin level. Asynchronous to `clk`.
- `sda_oe`  out  1  1 = pull SDA low (open-drain). 0 = release.
- `reg_raddr`  in  REG_AW  host read address.
- `reg_rdata`  out  8  register[reg_raddr]. Combinational.
- `wr_stb`  out  1  one-cycle pulse for each data byte written from the bus.
- `wr_addr`  out  REG_AW  register written; valid with `wr_stb`, held otherwise.
- `wr_data`  out  8  byte written; valid with `wr_stb`, held otherwise.
- `busy`  out  1  1 from START detect to STOP detect.

## Operation
- **Synchronisers and edge detection**
  - 2-FF synchronisers on `scl_i` and `sda_i`.
  - One further delay register per line for edge detection.
  - All protocol logic uses the synchronised signals only.
- **Bus conditions**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - A START in any state, including a repeated START, goes to ADDR and clears the bit counter.
  - A STOP in any state goes to IDLE and releases SDA.
- **Bit handling**
  - Bits are sampled on the detected SCL rise, MSB first.
  - `sda_oe` changes only on the detected SCL fall.
- **State machine**
  - IDLE → ADDR on START.
  - ADDR: shift in 8 bits.
    - Upper 7 bits == SLAVE_ADDR: go to ADDR_ACK.
    - Otherwise: go to IGNORE, with `sda_oe`=0 until the next START or STOP.
  - ADDR_ACK: `sda_oe`=1 from the SCL fall after bit 8 to the SCL fall after the 9th clock. Next state:
    - R/W=0: PTR.
    - R/W=1: RDATA, with shift register loaded from reg[ptr].
  - PTR: shift in 8 bits. ptr = byte[REG_AW-1:0]; upper bits are ignored. Then PTR_ACK (ACK as above) → WDATA.
  - WDATA: shift in 8 bits.
    - On the 8th rise: reg[ptr] ← byte, `wr_stb`=1, `wr_addr`=ptr, `wr_data`=byte.
    - ptr ← ptr+1 mod 2^REG_AW.
    - Then WDATA_ACK (ACK) → WDATA.
  - RDATA: on each SCL fall, `sda_oe` = ~current bit. After bit 8, release SDA on the SCL fall → RACK.
  - RACK: sample the master's ACK on the 9th rise; ptr ← ptr+1 mod 2^REG_AW in either case.
    - SDA=0 (ACK): load reg[ptr] → RDATA.
    - SDA=1 (NACK): → IGNORE.
- **Pointer**
  - ptr persists across transactions.
  - A read with no preceding pointer write starts at the current ptr.
- **Host port**: a host read and a bus write to the same address in the same cycle returns the old value on `reg_rdata`; the new value appears the next cycle.

## Timing
- **Reset values**: after `rst` high at a clock edge:
  - Outputs: `sda_oe`=0, `wr_stb`=0, `wr_addr`=0, `wr_data`=0, `busy`=0.
  - Internal: all registers 0, ptr=0, state IDLE.
- **Reset mid-transaction**: SDA is released on the first clock after reset is sampled. The bus master sees the remainder of the transfer as NACK.
- **Detection latency**: a pin change is detected 3 `clk` cycles after it occurs.
- **Output latency**:
  - `sda_oe` updates 1 cycle after the detected SCL fall.
  - `wr_stb` asserts 1 cycle after the detected 8th SCL rise and lasts exactly 1 cycle.
- **Minimum pin timing**: SCL high and low periods ≥ 4 `clk` periods. SDA setup to SCL rise ≥ 3 `clk` periods. Operation below these limits is undefined.
- **`busy`**: rises 1 cycle after START is detected; falls 1 cycle after STOP is detected.

## Test plan
- **Write burst**: START, 0xA0, 0x03, 0x11, 0x22, STOP.
  - `sda_oe` ACK on all 4 bytes.
  - `wr_stb` pulses with (3,0x11) then (4,0x22).
  - `reg_rdata`@3 = 0x11, @4 = 0x22.
- **Combined read**: after the write burst, START, 0xA0, 0x03, repeated START, 0xA1; master ACKs byte 1, NACKs byte 2; STOP.
  - SDA carries 0x11 then 0x22.
  - No `wr_stb`.
  - A following START, 0xA1 read returns reg[5]=0x00.
- **Address mismatch**: START, 0xA2, 0x05, STOP.
  - `sda_oe`=0 throughout.
  - No `wr_stb`.
  - SDA high at every 9th clock.
- **Pointer wrap**: START, 0xA0, 0x0F, 0xAA, 0xBB, STOP → reg[15]=0xAA, reg[0]=0xBB.
- **Upper pointer bits**: pointer byte 0x13, data 0x5C → `wr_addr`=3, reg[3]=0x5C.
- **Reset mid-read**: pulse `rst` while the slave is driving a 0 bit.
  - Next cycle: `sda_oe`=0, `busy`=0, all registers read 0x00.
  - A subsequent valid write is ACKed normally.
